// File: rtl/axis_adc_packetizer_pkg.sv
// Shared types, counter widths and parameter-legality helper for the ADC packetizer.
package axis_adc_packetizer_pkg;

  // Serialiser FSM states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

  localparam int unsigned OVF_CNT_W = 16;
  localparam int unsigned PKT_CNT_W = 32;

  // True when the parameter set describes a buildable packetizer
  function automatic bit params_legal(input int unsigned adc_w,
                                      input int unsigned tdata_w,
                                      input int unsigned num_ch,
                                      input int unsigned pkt_beats,
                                      input int unsigned fifo_depth);
    return (tdata_w >= adc_w) && ((tdata_w % 8) == 0) && (num_ch >= 1) &&
           ((pkt_beats % num_ch) == 0) && (fifo_depth >= 2) &&
           ((fifo_depth & (fifo_depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head entry is visible whenever not empty.
module axis_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             push_ok_c;
  logic             pop_ok_c;

  assign empty_c    = (wr_ptr_q == rd_ptr_q);
  assign full_c     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign push_ok_c  = push & ~full_c;
  assign pop_ok_c   = pop & ~empty_c;
  assign pop_data_c = mem[rd_ptr_q[AW-1:0]];

  // Storage array, written on accepted pushes
  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

  // Read/write pointers with an extra wrap bit to tell full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_ok_c)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/axis_adc_packetizer.sv
// AXI4-Stream master: buffers ADC sample vectors, serialises channels into beats, marks packets.
module axis_adc_packetizer
  import axis_adc_packetizer_pkg::*;
#(
  parameter int unsigned ADC_WIDTH   = 14,
  parameter int unsigned TDATA_WIDTH = 16,
  parameter int unsigned NUM_CH      = 1,
  parameter int unsigned PKT_BEATS   = 64,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                          m_axis_aclk,
  input  logic                          m_axis_aresetn,
  input  logic                          s_sample_valid,
  input  logic [NUM_CH*ADC_WIDTH-1:0]   s_sample_data,
  input  logic                          cfg_enable,
  input  logic                          cfg_test_mode,
  input  logic                          cfg_signed,
  output logic [TDATA_WIDTH-1:0]        m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0]      m_axis_tstrb,
  output logic [TDATA_WIDTH/8-1:0]      m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [OVF_CNT_W-1:0]          overflow_cnt,
  output logic [PKT_CNT_W-1:0]          pkt_cnt
);

  localparam int unsigned VEC_W  = NUM_CH * ADC_WIDTH;
  localparam int unsigned FIFO_W = VEC_W + 1;
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BEAT_W = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;

  if (!params_legal(ADC_WIDTH, TDATA_WIDTH, NUM_CH, PKT_BEATS, FIFO_DEPTH)) begin : g_param_check
    $error("axis_adc_packetizer: illegal parameter combination");
  end

  // Zero- or sign-extend one channel sample to the beat width
  function automatic logic [TDATA_WIDTH-1:0] extend(input logic [ADC_WIDTH-1:0] s,
                                                    input logic                 sx);
    return sx ? TDATA_WIDTH'($signed(s)) : TDATA_WIDTH'(s);
  endfunction

  ser_state_e             state_q, state_d;
  logic [ADC_WIDTH-1:0]   test_cnt_q, test_cnt_d;
  logic [OVF_CNT_W-1:0]   ovf_q, ovf_d;
  logic [PKT_CNT_W-1:0]   pkt_q, pkt_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [VEC_W-1:0]       vec_q, vec_d;
  logic                   sign_q, sign_d;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;

  logic                   strobe_c;
  logic                   fifo_push_c;
  logic                   fifo_pop_c;
  logic                   fifo_full_c;
  logic                   fifo_empty_c;
  logic [FIFO_W-1:0]      fifo_wdata_c;
  logic [FIFO_W-1:0]      fifo_rdata_c;
  logic [VEC_W-1:0]       test_vec_c;
  logic                   handshake_c;
  logic                   last_beat_c;
  logic                   load_c;
  logic                   load_sx_c;

  assign strobe_c     = s_sample_valid & cfg_enable;
  assign fifo_push_c  = strobe_c & ~fifo_full_c;
  assign fifo_wdata_c = {cfg_test_mode, (cfg_test_mode ? test_vec_c : s_sample_data)};
  assign handshake_c  = tvalid_q & m_axis_tready;
  assign last_beat_c  = (beat_q == BEAT_W'(PKT_BEATS - 1));

  // Counter test pattern: consecutive values, one per channel
  always_comb begin
    test_vec_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      test_vec_c[i*ADC_WIDTH +: ADC_WIDTH] = test_cnt_q + ADC_WIDTH'(i);
    end
  end

  axis_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (m_axis_aclk),
    .rst_n      (m_axis_aresetn),
    .push       (fifo_push_c),
    .push_data  (fifo_wdata_c),
    .pop        (fifo_pop_c),
    .pop_data_c (fifo_rdata_c),
    .full_c     (fifo_full_c),
    .empty_c    (fifo_empty_c)
  );

  // Next-state: capture accounting, serialiser FSM, packet tracking
  always_comb begin
    state_d    = state_q;
    test_cnt_d = test_cnt_q;
    ovf_d      = ovf_q;
    pkt_d      = pkt_q;
    beat_d     = beat_q;
    ch_d       = ch_q;
    vec_d      = vec_q;
    sign_d     = sign_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    fifo_pop_c = 1'b0;
    load_c     = 1'b0;
    load_sx_c  = 1'b0;

    // A dropped vector still consumes pattern values so the gap is visible downstream
    if (strobe_c && cfg_test_mode) begin
      test_cnt_d = test_cnt_q + ADC_WIDTH'(NUM_CH);
    end
    if (strobe_c && fifo_full_c && (ovf_q != '1)) begin
      ovf_d = ovf_q + OVF_CNT_W'(1);
    end

    if (handshake_c) begin
      if (last_beat_c) begin
        beat_d = '0;
        pkt_d  = pkt_q + PKT_CNT_W'(1);
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_c) begin
          load_c  = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (handshake_c) begin
          if (ch_q != CH_W'(NUM_CH - 1)) begin
            ch_d    = ch_q + CH_W'(1);
            tdata_d = extend(vec_q[ADC_WIDTH-1:0], sign_q);
            vec_d   = vec_q >> ADC_WIDTH;
            tlast_d = (beat_d == BEAT_W'(PKT_BEATS - 1));
          end else if (!fifo_empty_c) begin
            load_c = 1'b1;
          end else begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pop the head vector and present its ch0; the rest waits in vec_q
    if (load_c) begin
      fifo_pop_c = 1'b1;
      load_sx_c  = cfg_signed & ~fifo_rdata_c[VEC_W];
      sign_d     = load_sx_c;
      ch_d       = '0;
      tdata_d    = extend(fifo_rdata_c[ADC_WIDTH-1:0], load_sx_c);
      vec_d      = fifo_rdata_c[VEC_W-1:0] >> ADC_WIDTH;
      tvalid_d   = 1'b1;
      tlast_d    = (beat_d == BEAT_W'(PKT_BEATS - 1));
    end
  end

  // State and output registers
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_q    <= ST_IDLE;
      test_cnt_q <= '0;
      ovf_q      <= '0;
      pkt_q      <= '0;
      beat_q     <= '0;
      ch_q       <= '0;
      vec_q      <= '0;
      sign_q     <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      test_cnt_q <= test_cnt_d;
      ovf_q      <= ovf_d;
      pkt_q      <= pkt_d;
      beat_q     <= beat_d;
      ch_q       <= ch_d;
      vec_q      <= vec_d;
      sign_q     <= sign_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tstrb  = '1;
  assign m_axis_tkeep  = '1;
  assign overflow_cnt  = ovf_q;
  assign pkt_cnt       = pkt_q;

endmodule
